// File: rtl/uart_mem_streamer_pkg.sv
// Shared types for the UART memory streamer: FSM state encoding and the
// bytes-per-word framing helper.
package uart_mem_streamer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    TX_READ,
    TX_WAIT,
    TX_LOAD,
    TX_BYTE,
    TX_GAP,
    RX_COLLECT,
    RX_WRITE,
    DONE
  } streamer_state_t;

  function automatic int unsigned bytes_per_word(input int unsigned word_w,
                                                 input int unsigned byte_w);
    return (word_w + byte_w - 1) / byte_w;
  endfunction

endpackage

// File: rtl/uart_mem_streamer_word_byte_packer.sv
// One-word byte packer: parallel load then LSB-first shift-out for TX, or
// byte-indexed assembly for RX, sharing one register and one byte counter.
module word_byte_packer
  import uart_mem_streamer_pkg::*;
#(
  parameter int  WORD_W = 24,
  parameter int  BYTE_W = 8,
  localparam int NBYTES = bytes_per_word(WORD_W, BYTE_W),
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [WORD_W-1:0] word_in,
  input  logic              shift,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [BYTE_W-1:0] low_byte,
  output logic [WORD_W-1:0] word_out,
  output logic [IDX_W-1:0]  byte_idx,
  output logic              last_byte
);

  localparam int REG_W = NBYTES * BYTE_W;

  logic [REG_W-1:0] sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_next;

  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));
  assign idx_next  = last_byte ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    if (clr) begin
      sh_d  = '0;
      idx_d = '0;
    end else if (load) begin
      // zero-extension makes the unused top bits of the last byte go out as 0
      sh_d  = REG_W'(word_in);
      idx_d = '0;
    end else if (shift) begin
      sh_d  = sh_q >> BYTE_W;
      idx_d = idx_next;
    end else if (byte_vld) begin
      sh_d[int'(idx_q)*BYTE_W +: BYTE_W] = byte_in;
      idx_d = idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

  assign low_byte = sh_q[BYTE_W-1:0];
  assign word_out = sh_q[WORD_W-1:0];
  assign byte_idx = idx_q;

endmodule

// File: rtl/uart_mem_streamer.sv
// Host-side UART memory streamer: sends tx_len source words, then collects rx_len
// words into the sink RAM. Optional RX idle timeout: UART_MEM_STREAMER_RX_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for start
// TX_READ    | source address driven with word index
// TX_WAIT    | source RAM read latency
// TX_LOAD    | source word loaded into the packer
// TX_BYTE    | wait for UART ready, launch low byte
// TX_GAP     | skip one cycle of stale ready; next byte or next word
// RX_COLLECT | assemble received bytes into a word
// RX_WRITE   | write assembled word to the sink RAM
// DONE       | session finished, done held until next start
module uart_mem_streamer
  import uart_mem_streamer_pkg::*;
#(
  parameter int  MEM_WORD_LENGTH   = 24,
  parameter int  MEM_DEPTH         = 4096,
  parameter int  UART_WIDTH        = 8,
  parameter int  RX_TIMEOUT_CYCLES = 5000000,
  localparam int ADDR_W            = $clog2(MEM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W:0]            tx_len,
  input  logic [ADDR_W:0]            rx_len,
  output logic [ADDR_W-1:0]          src_addr,
  input  logic [MEM_WORD_LENGTH-1:0] src_data,
  output logic [ADDR_W-1:0]          dst_addr,
  output logic [MEM_WORD_LENGTH-1:0] dst_data,
  output logic                       dst_wrEn,
  input  logic                       txByteReady,
  output logic                       txByteStart,
  output logic [UART_WIDTH-1:0]      byteForTx,
  input  logic                       rx_new_byte_indicate,
  input  logic [UART_WIDTH-1:0]      byteFromRx,
  output logic                       busy,
  output logic                       done,
  output logic                       rx_timeout
);

  localparam int LEN_W    = ADDR_W + 1;
  localparam int BPW      = bytes_per_word(MEM_WORD_LENGTH, UART_WIDTH);
  localparam int PK_IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  streamer_state_t state_q, state_d;
  logic [LEN_W-1:0] word_q, word_d, word_inc;
  logic [LEN_W-1:0] tx_len_q, tx_len_d, rx_len_q, rx_len_d;
  logic [LEN_W-1:0] tx_len_sat, rx_len_sat;
  logic tx_start_q, tx_start_d;
  logic [UART_WIDTH-1:0] byte_q, byte_d;
  logic rx_timeout_q, rx_timeout_d;
  logic timeout_hit;

  logic pk_clr, pk_load, pk_shift, pk_byte_vld, pk_last;
  logic [UART_WIDTH-1:0] pk_low;
  logic [MEM_WORD_LENGTH-1:0] pk_word;
  logic [PK_IDX_W-1:0] pk_idx;

  word_byte_packer #(
    .WORD_W (MEM_WORD_LENGTH),
    .BYTE_W (UART_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr),
    .load      (pk_load),
    .word_in   (src_data),
    .shift     (pk_shift),
    .byte_vld  (pk_byte_vld),
    .byte_in   (byteFromRx),
    .low_byte  (pk_low),
    .word_out  (pk_word),
    .byte_idx  (pk_idx),
    .last_byte (pk_last)
  );

  assign tx_len_sat = (tx_len > LEN_W'(MEM_DEPTH)) ? LEN_W'(MEM_DEPTH) : tx_len;
  assign rx_len_sat = (rx_len > LEN_W'(MEM_DEPTH)) ? LEN_W'(MEM_DEPTH) : rx_len;
  assign word_inc   = word_q + LEN_W'(1);

`ifdef UART_MEM_STREAMER_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(RX_TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // cleared by any received byte and by every entry into RX_COLLECT
  always_comb begin
    to_cnt_d = '0;
    if (state_q == RX_COLLECT && !rx_new_byte_indicate) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  assign timeout_hit = (state_q == RX_COLLECT) && !rx_new_byte_indicate &&
                       (to_cnt_q == TO_W'(RX_TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    tx_len_d     = tx_len_q;
    rx_len_d     = rx_len_q;
    tx_start_d   = 1'b0;
    byte_d       = byte_q;
    rx_timeout_d = rx_timeout_q;
    pk_clr       = 1'b0;
    pk_load      = 1'b0;
    pk_shift     = 1'b0;
    pk_byte_vld  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          word_d       = '0;
          tx_len_d     = tx_len_sat;
          rx_len_d     = rx_len_sat;
          rx_timeout_d = 1'b0;
          if (tx_len_sat != '0) begin
            state_d = TX_READ;
          end else if (rx_len_sat != '0) begin
            state_d = RX_COLLECT;
            pk_clr  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      TX_READ: state_d = TX_WAIT;
      TX_WAIT: state_d = TX_LOAD;
      TX_LOAD: begin
        pk_load = 1'b1;
        state_d = TX_BYTE;
      end
      TX_BYTE: begin
        if (txByteReady) begin
          tx_start_d = 1'b1;
          byte_d     = pk_low;
          pk_shift   = 1'b1;
          state_d    = TX_GAP;
        end
      end
      TX_GAP: begin
        // packer index wraps to 0 once the last byte of the word has gone out
        if (pk_idx != '0) begin
          state_d = TX_BYTE;
        end else if (word_inc == tx_len_q) begin
          word_d = '0;
          if (rx_len_q != '0) begin
            state_d = RX_COLLECT;
            pk_clr  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          word_d  = word_inc;
          state_d = TX_READ;
        end
      end
      RX_COLLECT: begin
        if (rx_new_byte_indicate) begin
          pk_byte_vld = 1'b1;
          if (pk_last) state_d = RX_WRITE;
        end else if (timeout_hit) begin
          state_d      = DONE;
          rx_timeout_d = 1'b1;
        end
      end
      RX_WRITE: begin
        // a byte landing here becomes byte 0 of the next word
        pk_byte_vld = rx_new_byte_indicate;
        word_d      = word_inc;
        state_d     = (word_inc == rx_len_q) ? DONE : RX_COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      tx_len_q     <= '0;
      rx_len_q     <= '0;
      tx_start_q   <= 1'b0;
      byte_q       <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      tx_len_q     <= tx_len_d;
      rx_len_q     <= rx_len_d;
      tx_start_q   <= tx_start_d;
      byte_q       <= byte_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  assign src_addr    = word_q[ADDR_W-1:0];
  assign dst_addr    = word_q[ADDR_W-1:0];
  assign dst_data    = pk_word;
  assign dst_wrEn    = (state_q == RX_WRITE);
  assign txByteStart = tx_start_q;
  assign byteForTx   = byte_q;
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
  assign rx_timeout  = rx_timeout_q;

endmodule
